factor_round: RTL
=================

Name: factor_round

Overview:
- Game-round engine for the factorization game; sits directly downstream of the ready/number-latch stage.
- On the rising edge of RUN_IN, loads a composite target selected by NUM (0-9) from a fixed table.
- The player strikes off prime factors with four buttons (2, 3, 5, 7) against a per-round seconds countdown.
- Reports the remaining value, hit/miss counts, time left, and the WIN/LOSE outcome to the display stage.

Parameters:
- CNT_MAX, 26'd49_999_999: 1 Hz tick divider terminal count; a tick fires when the counter equals CNT_MAX.
- TIME_LIMIT, 6'd30: seconds per round.
- MAX_MISS, 2'd3: wrong presses allowed before a loss.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- RUN_IN  in  1  level from the ready stage; high while both players are ready.
- NUM  in  4  latched round index, 0-9.
- BTN_P2  in  1  debounced level, prime 2 button.
- BTN_P3  in  1  debounced level, prime 3 button.
- BTN_P5  in  1  debounced level, prime 5 button.
- BTN_P7  in  1  debounced level, prime 7 button.
- VALUE  out  8  remaining unfactored value.
- HITS  out  4  correct presses this round.
- MISS  out  2  wrong presses this round.
- TIME_LEFT  out  6  seconds remaining.
- PLAYING  out  1  high in PLAY.
- WIN  out  1  high in WIN.
- LOSE  out  1  high in LOSE.

Behaviour:
- Reset: all outputs 0, state IDLE, divider 0, internal edge registers 0.
- Edge detect: RUN_IN and the four buttons are registered each cycle; rise = input & ~registered_input.
- States: IDLE, LOAD, PLAY, WIN, LOSE.
- IDLE -> LOAD on a RUN_IN rise. A RUN_IN held high out of reset counts as a rise on the first sampled cycle.
- LOAD (1 cycle):
  - VALUE <= TABLE[NUM]; NUM 10-15 selects entry 0.
  - HITS <= 0, MISS <= 0, TIME_LEFT <= TIME_LIMIT, divider cleared.
  - Next state PLAY.
- TABLE[0..9] = 12, 18, 20, 28, 30, 42, 45, 60, 84, 210. Every entry factors over {2,3,5,7} and fits 8 bits.
- PLAY, press handling:
  - A cycle with exactly one button rise is a press. Zero or more than one rise: nothing happens (multi-press is ignored, no miss charged).
  - Press of p with VALUE % p == 0: VALUE <= VALUE / p and HITS <= HITS + 1, both on the same edge the rise is seen (one cycle after the button is first sampled high).
  - Otherwise: MISS <= MISS + 1 and VALUE is unchanged.
  - HITS saturates at 15; it cannot exceed 8 for the given table.
- PLAY, timer:
  - Divider counts every cycle; a tick at CNT_MAX reloads it to 0 and decrements TIME_LEFT.
  - TIME_LEFT never wraps below 0.
- PLAY, exits (priority in this order, evaluated on registered values, transition one cycle after the causing update):
  1. RUN_IN low -> IDLE. Abort: VALUE, HITS, MISS, TIME_LEFT cleared to 0.
  2. VALUE == 1 -> WIN.
  3. MISS == MAX_MISS -> LOSE.
  4. TIME_LEFT == 0 -> LOSE.
- Consequence: a press that reaches VALUE == 1 on the same edge as the last tick takes TIME_LEFT to 0 yields WIN.
- WIN/LOSE:
  - Hold VALUE, HITS, MISS, TIME_LEFT frozen; buttons are ignored.
  - Return to IDLE when RUN_IN is low; the counters stay visible in IDLE until the next LOAD.
- Output decode: PLAYING/WIN/LOSE are registered state decodes, mutually exclusive. All three are 0 in IDLE and LOAD.
- Arithmetic: division and modulo by the constants 2, 3, 5, 7 on the 8-bit VALUE only; no generic divider.

Decomposition:
- Package factor_pkg:
  - state enum (IDLE, LOAD, PLAY, WIN, LOSE);
  - VAL_W = 8;
  - prime constants 2, 3, 5, 7;
  - 10-entry target table constant.
- Sub-module sec_tick:
  - divider with synchronous clear input and one-cycle tick output, parameterised by CNT_MAX;
  - cleared in LOAD and enabled only in PLAY.

Test Plan (CNT_MAX = 9 unless stated):
- NUM=0, RUN_IN rise, press 2, 2, 3 with gaps -> VALUE 12 -> 6 -> 3 -> 1; HITS=3; WIN asserted one cycle after VALUE=1; MISS=0.
- NUM=9, press 7, 5, 3, 2 -> VALUE 210 -> 30 -> 6 -> 2 -> 1; WIN; then RUN_IN low -> IDLE with VALUE still 1.
- NUM=6 (45), press 2 three times -> MISS 1, 2, 3; LOSE one cycle after MISS=3; VALUE stays 45; a later press of 3 has no effect.
- TIME_LIMIT=3, NUM=2, no presses -> TIME_LEFT 3, 2, 1, 0 at 10-cycle intervals; LOSE one cycle after 0.
- NUM=1 (18), BTN_P2 and BTN_P3 rise in the same cycle -> no change to VALUE, HITS, or MISS. A single BTN_P3 press afterwards -> VALUE=6.
- Abort and reset:
  - NUM=3 (28), press 2 -> VALUE 14; drop RUN_IN -> IDLE with all counters 0.
  - Re-raise RUN_IN -> VALUE 28, TIME_LEFT=30 (default).
  - Assert RST mid-PLAY -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/factor_pkg.sv
// Shared types and constants for the factorization game round engine.
package factor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam int unsigned VAL_W = 8;

    localparam logic [VAL_W-1:0] PRIME_2 = 8'd2;
    localparam logic [VAL_W-1:0] PRIME_3 = 8'd3;
    localparam logic [VAL_W-1:0] PRIME_5 = 8'd5;
    localparam logic [VAL_W-1:0] PRIME_7 = 8'd7;

    // Entry 0 is the least significant slice.
    localparam logic [9:0][VAL_W-1:0] TARGETS = {
        8'd210, 8'd84, 8'd60, 8'd45, 8'd42,
        8'd30,  8'd28, 8'd20, 8'd18, 8'd12
    };

    typedef struct packed {
        logic             hit;
        logic [VAL_W-1:0] quot;
    } div_res_t;

    function automatic logic [VAL_W-1:0] target_of(input logic [3:0] num);
        logic [3:0] idx;
        idx = (num > 4'd9) ? 4'd0 : num;
        return TARGETS[idx];
    endfunction

    // press is one-hot {7,5,3,2}; each arm divides by a constant only.
    function automatic div_res_t try_divide(input logic [VAL_W-1:0] v,
                                            input logic [3:0]       press);
        div_res_t r;
        case (press)
            4'b0001: begin r.hit = (v % PRIME_2) == '0; r.quot = v / PRIME_2; end
            4'b0010: begin r.hit = (v % PRIME_3) == '0; r.quot = v / PRIME_3; end
            4'b0100: begin r.hit = (v % PRIME_5) == '0; r.quot = v / PRIME_5; end
            4'b1000: begin r.hit = (v % PRIME_7) == '0; r.quot = v / PRIME_7; end
            default: begin r.hit = 1'b0;                r.quot = v;           end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/factor_round_sec_tick.sv
// Seconds divider: counts while enabled, one-cycle tick at the terminal count.
module sec_tick #(
    parameter logic [25:0] CNT_MAX = 26'd49_999_999
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [25:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 26'd1;
        end
    end

endmodule

// File: rtl/factor_round.sv
// Round engine: loads a composite target, applies prime-button presses
// against a seconds countdown, and reports WIN/LOSE.
module factor_round
    import factor_pkg::*;
#(
    parameter logic [25:0] CNT_MAX    = 26'd49_999_999,
    parameter logic [5:0]  TIME_LIMIT = 6'd30,
    parameter logic [1:0]  MAX_MISS   = 2'd3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN_IN,
    input  logic [3:0]       NUM,
    input  logic             BTN_P2,
    input  logic             BTN_P3,
    input  logic             BTN_P5,
    input  logic             BTN_P7,
    output logic [VAL_W-1:0] VALUE,
    output logic [3:0]       HITS,
    output logic [1:0]       MISS,
    output logic [5:0]       TIME_LEFT,
    output logic             PLAYING,
    output logic             WIN,
    output logic             LOSE
);

    state_t     state, next_state;
    logic       run_q;
    logic       run_rise;
    logic [3:0] btn, btn_q, btn_rise;
    logic       tick, tick_clr, tick_en;
    logic       playing_d, win_d, lose_d;
    div_res_t   res;

    assign btn      = {BTN_P7, BTN_P5, BTN_P3, BTN_P2};
    assign run_rise = RUN_IN & ~run_q;
    assign btn_rise = btn & ~btn_q;
    assign res      = try_divide(VALUE, btn_rise);
    assign tick_clr = (state == ST_LOAD);
    assign tick_en  = (state == ST_PLAY);

    sec_tick #(
        .CNT_MAX(CNT_MAX)
    ) u_sec_tick (
        .clk (CLK),
        .rst (RST),
        .clr (tick_clr),
        .en  (tick_en),
        .tick(tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            run_q <= 1'b0;
            btn_q <= '0;
        end else begin
            run_q <= RUN_IN;
            btn_q <= btn;
        end
    end

    // State register; the flags are registered from the next-state decode
    // so they line up exactly with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            PLAYING <= 1'b0;
            WIN     <= 1'b0;
            LOSE    <= 1'b0;
        end else begin
            state   <= next_state;
            PLAYING <= playing_d;
            WIN     <= win_d;
            LOSE    <= lose_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (run_rise) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_PLAY;
            ST_PLAY: begin
                if (!RUN_IN)                 next_state = ST_IDLE;
                else if (VALUE == 8'd1)      next_state = ST_WIN;
                else if (MISS == MAX_MISS)   next_state = ST_LOSE;
                else if (TIME_LEFT == '0)    next_state = ST_LOSE;
            end
            ST_WIN, ST_LOSE: if (!RUN_IN) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        playing_d = (next_state == ST_PLAY);
        win_d     = (next_state == ST_WIN);
        lose_d    = (next_state == ST_LOSE);
    end

    // Presses and ticks only land while the round stays in PLAY, so the
    // counters that caused an exit are the ones left frozen on display.
    always_ff @(posedge CLK) begin
        if (RST) begin
            VALUE     <= '0;
            HITS      <= '0;
            MISS      <= '0;
            TIME_LEFT <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    VALUE     <= target_of(NUM);
                    HITS      <= '0;
                    MISS      <= '0;
                    TIME_LEFT <= TIME_LIMIT;
                end
                ST_PLAY: begin
                    if (!RUN_IN) begin
                        VALUE     <= '0;
                        HITS      <= '0;
                        MISS      <= '0;
                        TIME_LEFT <= '0;
                    end else if (next_state == ST_PLAY) begin
                        if ($onehot(btn_rise)) begin
                            if (res.hit) begin
                                VALUE <= res.quot;
                                if (HITS != 4'hF) HITS <= HITS + 4'd1;
                            end else begin
                                MISS <= MISS + 2'd1;
                            end
                        end
                        if (tick && TIME_LEFT != '0) TIME_LEFT <= TIME_LEFT - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
